instruction_fetch: RTL and testbench

//   Upstream neighbour of the instruction decoder. Holds the PC, issues word reads
//   to instruction memory with a req/rvalid handshake, and buffers one fetched word.

---
 rtl/instruction_fetch.sv | 170 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: holds the PC, issues single-word reads to instruction memory,
// buffers one fetched word and hands it to the decoder over valid/ready.
// Control-transfer redirects squash any in-flight fetch.
// Optional feature macro: STALL_COUNT_EN adds o_stall_count, a saturating count of
// cycles in which a buffered instruction waits on the decoder.
//
// state | meaning
// REQ   | o_imem_req is high this cycle (right after reset it is low; that cycle raises it)
// WAIT  | request outstanding, capture the word on rvalid
// HOLD  | word buffered, waiting for the decoder to accept it
// DRAIN | squashed request outstanding, its response is thrown away
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr_out,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
`ifdef STALL_COUNT_EN
  output logic [31:0] o_stall_count,
`endif
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [1:0]  i_redirect_sel,
  input  logic [31:0] i_redirect_pc_base,
  input  logic [15:0] i_redirect_imm,
  input  logic [25:0] i_redirect_addr,
  input  logic [31:0] i_redirect_reg
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] r_instr_out;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;

  logic        w_redirect_take;
  logic [31:0] w_seq_pc;
  logic [31:0] w_target;

  assign w_redirect_take = i_redirect && (i_redirect_sel != 2'b11);
  assign w_seq_pc        = i_redirect_pc_base + 32'd4;

  // Redirect target; the low two bits of a jr register are dropped to stay word aligned.
  always_comb begin
    w_target = w_seq_pc + {{14{i_redirect_imm[15]}}, i_redirect_imm, 2'b00};
    case (i_redirect_sel)
      2'b01:   w_target = {w_seq_pc[31:28], i_redirect_addr, 2'b00};
      2'b10:   w_target = i_redirect_reg & 32'hFFFF_FFFC;
      default: w_target = w_seq_pc + {{14{i_redirect_imm[15]}}, i_redirect_imm, 2'b00};
    endcase
  end

  // Fetch FSM. The request strobe is registered: every transition into REQ raises it
  // together with the address, so the request is visible for the whole REQ cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= 32'd0;
      r_instr_out   <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
    end else begin
      r_imem_req <= 1'b0;
      if (w_redirect_take) begin
        r_pc          <= w_target;
        r_instr_valid <= 1'b0;
        case (r_state)
          S_REQ: begin
            if (r_imem_req) begin
              r_state <= S_DRAIN;
            end else begin
              // first cycle after reset: nothing issued yet, so fetch the target directly
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_target;
            end
          end
          S_WAIT: begin
            if (i_imem_rvalid) begin
              r_state     <= S_REQ;
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_target;
            end else begin
              r_state <= S_DRAIN;
            end
          end
          default: begin
            r_state     <= S_REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= w_target;
          end
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            if (r_imem_req) begin
              r_state <= S_WAIT;
            end else begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_pc;
            end
          end
          S_WAIT: begin
            if (i_imem_rvalid) begin
              r_instr_out   <= i_imem_rdata;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_pc          <= r_pc + PC_STEP;
              r_state       <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (r_instr_valid && i_instr_ready) begin
              r_instr_valid <= 1'b0;
              r_state       <= S_REQ;
              r_imem_req    <= 1'b1;
              r_imem_addr   <= r_pc;
            end
          end
          default: begin
            if (i_imem_rvalid) begin
              r_state     <= S_REQ;
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_pc;
            end
          end
        endcase
      end
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_imem_addr;
  assign o_instr_out   = r_instr_out;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;

`ifdef STALL_COUNT_EN
  logic [31:0] r_stall_count;

  // Count decoder back-pressure cycles, saturating at all ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_count <= 32'd0;
    end else if (r_instr_valid && !i_instr_ready && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed sequences, a redirect-target
// vector table, and a randomized run against a transaction-level reference model.
module tb_instruction_fetch;

  logic        i_clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr_out;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic        i_redirect;
  logic [1:0]  i_redirect_sel;
  logic [31:0] i_redirect_pc_base;
  logic [15:0] i_redirect_imm;
  logic [25:0] i_redirect_addr;
  logic [31:0] i_redirect_reg;
`ifdef STALL_COUNT_EN
  logic [31:0] o_stall_count;
`endif

  instruction_fetch dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .o_imem_req         (o_imem_req),
    .o_imem_addr        (o_imem_addr),
    .i_imem_rvalid      (i_imem_rvalid),
    .i_imem_rdata       (i_imem_rdata),
    .o_instr_out        (o_instr_out),
    .o_instr_pc         (o_instr_pc),
    .o_instr_valid      (o_instr_valid),
`ifdef STALL_COUNT_EN
    .o_stall_count      (o_stall_count),
`endif
    .i_instr_ready      (i_instr_ready),
    .i_redirect         (i_redirect),
    .i_redirect_sel     (i_redirect_sel),
    .i_redirect_pc_base (i_redirect_pc_base),
    .i_redirect_imm     (i_redirect_imm),
    .i_redirect_addr    (i_redirect_addr),
    .i_redirect_reg     (i_redirect_reg)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  logic        pend       = 1'b0;
  logic        pend_stale = 1'b0;
  logic [31:0] pend_addr  = 32'd0;
  int          pend_cnt   = 0;
  int          mem_lat    = 1;
  logic        mem_rand   = 1'b0;
  logic        resp_now   = 1'b0;
  logic        resp_stale = 1'b0;
  logic [31:0] resp_addr  = 32'd0;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] base;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] rval;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs[7];

  function automatic logic [31:0] hash(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] ref_target(input logic [1:0] sel, input logic [31:0] base,
                                             input logic [15:0] imm, input logic [25:0] jaddr,
                                             input logic [31:0] rval);
    int off;
    off = int'(signed'(imm)) * 4;
    case (sel)
      2'd0:    return base + 32'd4 + 32'(off);
      2'd1:    return ((base + 32'd4) & 32'hF000_0000) | (32'(jaddr) << 2);
      default: return rval & ~32'd3;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // One-cycle memory with configurable latency; response data is a hash of the address.
  task automatic mem_update();
    i_imem_rvalid = 1'b0;
    resp_now      = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = hash(pend_addr);
        resp_now      = 1'b1;
        resp_addr     = pend_addr;
        resp_stale    = pend_stale;
        pend          = 1'b0;
      end
    end
    if (o_imem_req) begin
      pend       = 1'b1;
      pend_addr  = o_imem_addr;
      pend_stale = 1'b0;
      pend_cnt   = mem_rand ? int'($urandom_range(3, 1)) : mem_lat;
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    mem_update();
  endtask

  task automatic wait_req(input string nm);
    int i = 0;
    while (!o_imem_req && i < 40) begin
      step();
      i++;
    end
    check1(nm, o_imem_req, 1'b1);
  endtask

  task automatic wait_valid(input string nm);
    int i = 0;
    while (!o_instr_valid && i < 40) begin
      step();
      i++;
    end
    check1(nm, o_instr_valid, 1'b1);
  endtask

  task automatic check_zero(input string pfx);
    check1({pfx, "_req"}, o_imem_req, 1'b0);
    check({pfx, "_addr"}, o_imem_addr, 32'd0);
    check1({pfx, "_valid"}, o_instr_valid, 1'b0);
    check({pfx, "_out"}, o_instr_out, 32'd0);
    check({pfx, "_pc"}, o_instr_pc, 32'd0);
`ifdef STALL_COUNT_EN
    check({pfx, "_stall"}, o_stall_count, 32'd0);
`endif
  endtask

  task automatic do_reset();
    i_reset            = 1'b1;
    i_instr_ready      = 1'b0;
    i_redirect         = 1'b0;
    i_redirect_sel     = 2'd0;
    i_redirect_pc_base = 32'd0;
    i_redirect_imm     = 16'd0;
    i_redirect_addr    = 26'd0;
    i_redirect_reg     = 32'd0;
    i_imem_rvalid      = 1'b0;
    i_imem_rdata       = 32'd0;
    pend               = 1'b0;
    #1;
    check_zero("rst");
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    int nreq;
    int nval;
    int lastv;
    logic [31:0] exp_req;
    logic [31:0] exp_stall;
    logic        take;
    logic [31:0] exp_q[$];

    vecs[0] = '{2'd0, 32'h0000_0010, 16'hFFFE, 26'd0,          32'd0,          32'h0000_000C};
    vecs[1] = '{2'd2, 32'h0000_0000, 16'h0000, 26'd0,          32'h0000_0203,  32'h0000_0200};
    vecs[2] = '{2'd0, 32'h0000_0008, 16'h7FFF, 26'd0,          32'd0,          32'h0002_0008};
    vecs[3] = '{2'd1, 32'hEFFF_FFFC, 16'h0000, 26'h3FF_FFFF,   32'd0,          32'hFFFF_FFFC};
    vecs[4] = '{2'd0, 32'hFFFF_FFF8, 16'h0001, 26'd0,          32'd0,          32'h0000_0000};
    vecs[5] = '{2'd1, 32'h1234_5678, 16'h0000, 26'h000_0040,   32'd0,          32'h1000_0100};
    vecs[6] = '{2'd2, 32'h0000_0000, 16'h0000, 26'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFC};

    // Sequential fetch with 1-cycle memory and an always-ready decoder.
    do_reset();
    i_instr_ready = 1'b1;
    nreq  = 0;
    nval  = 0;
    lastv = -1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (o_imem_req && nreq < 3) begin
        check("seq_addr", o_imem_addr, 32'(nreq * 4));
        nreq++;
      end
      if (o_instr_valid) begin
        if (nval < 3) begin
          check("seq_pc", o_instr_pc, 32'(nval * 4));
          check("seq_data", o_instr_out, hash(32'(nval * 4)));
        end
        if (lastv >= 0) check("seq_gap", 32'(c - lastv), 32'd3);
        lastv = c;
        nval++;
      end
    end
    check("seq_nreq", 32'(nreq), 32'd3);
    check1("seq_nval", nval >= 3, 1'b1);

    // Decoder back-pressure for five cycles.
    do_reset();
    wait_valid("stall_wait");
`ifdef STALL_COUNT_EN
    check("stall_cnt0", o_stall_count, 32'd0);
`endif
    for (int i = 1; i <= 5; i++) begin
      step();
      check1("stall_valid", o_instr_valid, 1'b1);
      check("stall_out", o_instr_out, hash(32'd0));
      check("stall_pc", o_instr_pc, 32'd0);
      check1("stall_noreq", o_imem_req, 1'b0);
`ifdef STALL_COUNT_EN
      check("stall_cnt", o_stall_count, 32'(i));
`endif
    end
    i_instr_ready = 1'b1;
    step();
    check1("stall_consumed", o_instr_valid, 1'b0);
    check1("stall_nextreq", o_imem_req, 1'b1);
    check("stall_nextaddr", o_imem_addr, 32'd4);

    // Redirect target table, each applied while an instruction is held.
    for (int v = 0; v < 7; v++) begin
      i_instr_ready = 1'b0;
      wait_valid("tbl_hold");
      i_redirect         = 1'b1;
      i_redirect_sel     = vecs[v].sel;
      i_redirect_pc_base = vecs[v].base;
      i_redirect_imm     = vecs[v].imm;
      i_redirect_addr    = vecs[v].jaddr;
      i_redirect_reg     = vecs[v].rval;
      step();
      i_redirect = 1'b0;
      check1("tbl_dropped", o_instr_valid, 1'b0);
      wait_req("tbl_req");
      check("tbl_addr", o_imem_addr, vecs[v].exp_addr);
      wait_valid("tbl_valid");
      check("tbl_pc", o_instr_pc, vecs[v].exp_addr);
      check("tbl_data", o_instr_out, hash(vecs[v].exp_addr));
    end

    // Reserved selector is ignored; then sequential fetch wraps past the top of memory.
    i_redirect     = 1'b1;
    i_redirect_sel = 2'b11;
    i_redirect_reg = 32'h0000_0400;
    step();
    i_redirect = 1'b0;
    check1("rsv_valid", o_instr_valid, 1'b1);
    check("rsv_pc", o_instr_pc, 32'hFFFF_FFFC);
    mem_lat       = 3;
    i_instr_ready = 1'b1;
    step();
    check1("wrap_req", o_imem_req, 1'b1);
    check("wrap_addr", o_imem_addr, 32'h0000_0000);

    // Jump while waiting, response three cycles after the request must be drained.
    step();
    i_redirect         = 1'b1;
    i_redirect_sel     = 2'b01;
    i_redirect_pc_base = 32'd0;
    i_redirect_addr    = 26'h000_0040;
    step();
    i_redirect = 1'b0;
    check1("drain_req0", o_imem_req, 1'b0);
    check1("drain_valid0", o_instr_valid, 1'b0);
    step();
    check1("drain_req1", o_imem_req, 1'b0);
    check1("drain_valid1", o_instr_valid, 1'b0);
    step();
    check1("drain_req2", o_imem_req, 1'b1);
    check("drain_addr", o_imem_addr, 32'h0000_0100);
    wait_valid("drain_valid");
    check("drain_pc", o_instr_pc, 32'h0000_0100);
    check("drain_data", o_instr_out, hash(32'h0000_0100));

    // Reset while a fetch is outstanding.
    mem_lat = 1;
    wait_req("rstw_req");
    step();
    i_reset       = 1'b1;
    pend          = 1'b0;
    i_imem_rvalid = 1'b0;
    #1;
    check_zero("rstw");
    step();
    step();
    i_reset = 1'b0;
    wait_req("rstw_first");
    check("rstw_addr", o_imem_addr, 32'h0000_0000);

    // Randomized run against the transaction-level model.
    do_reset();
    mem_rand  = 1'b1;
    exp_req   = 32'h0000_0000;
    exp_stall = 32'd0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      step();
      if (exp_q.size() != 0) begin
        check1("rnd_valid", o_instr_valid, 1'b1);
        check("rnd_pc", o_instr_pc, exp_q[0]);
        check("rnd_data", o_instr_out, hash(exp_q[0]));
      end else begin
        check1("rnd_valid", o_instr_valid, 1'b0);
      end
      if (o_imem_req) begin
        check("rnd_addr", o_imem_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
`ifdef STALL_COUNT_EN
      check("rnd_stall", o_stall_count, exp_stall);
`endif
      i_instr_ready = ($urandom_range(99) < 60);
      i_redirect    = 1'b0;
      // a squashed fetch must land before another redirect is issued
      if (!(pend && pend_stale) && $urandom_range(9) == 0) begin
        i_redirect         = 1'b1;
        i_redirect_sel     = 2'($urandom_range(3));
        i_redirect_pc_base = $urandom;
        i_redirect_imm     = 16'($urandom);
        i_redirect_addr    = 26'($urandom);
        i_redirect_reg     = $urandom;
      end
      take = i_redirect && (i_redirect_sel != 2'b11);
      if (exp_q.size() != 0 && !i_instr_ready && exp_stall != 32'hFFFF_FFFF)
        exp_stall = exp_stall + 32'd1;
      if (exp_q.size() != 0 && i_instr_ready) void'(exp_q.pop_front());
      if (resp_now && !resp_stale && !take) exp_q.push_back(resp_addr);
      if (take) begin
        exp_q.delete();
        exp_req = ref_target(i_redirect_sel, i_redirect_pc_base, i_redirect_imm,
                             i_redirect_addr, i_redirect_reg);
        if (pend) pend_stale = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
